// File: rtl/vga_timing_decoder.sv
// Sink-side VGA timing recovery: samples hsync/vsync/DE on pixel strobes, recovers x/y,
// measures line/frame geometry and declares lock once two consecutive frames agree.
module vga_timing_decoder #(
  parameter int unsigned XW        = 11,
  parameter int unsigned YW        = 10,
  parameter int unsigned H_TIMEOUT = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_stb,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          active,
  output logic          pix_valid,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic          locked,
  output logic          lock_err,
  output logic [XW-1:0] h_total,
  output logic [XW-1:0] h_active,
  output logic [YW-1:0] v_total,
  output logic [YW-1:0] v_active
);

  localparam int unsigned TW = 12;
  localparam int unsigned SW = 2 * XW + 2 * YW;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            hs_prev_q, hs_prev_d;
  logic            vs_prev_q, vs_prev_d;
  logic            de_prev_q, de_prev_d;
  logic            h_seen_q, h_seen_d;
  logic            ref_valid_q, ref_valid_d;
  logic [XW-1:0]   h_cnt_q, h_cnt_d;
  logic [XW-1:0]   a_cnt_q, a_cnt_d;
  logic [YW-1:0]   v_cnt_q, v_cnt_d;
  logic [YW-1:0]   l_cnt_q, l_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [SW-1:0]   ref_q, ref_d;
  logic            pix_valid_q, pix_valid_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            frame_start_q, frame_start_d;
  logic            locked_q, locked_d;
  logic            lock_err_q, lock_err_d;
  logic [XW-1:0]   h_total_q, h_total_d;
  logic [XW-1:0]   h_active_q, h_active_d;
  logic [YW-1:0]   v_total_q, v_total_d;
  logic [YW-1:0]   v_active_q, v_active_d;
  logic [SW-1:0]   snap_c;

  logic hs_rise, vs_rise, de_fall, timeout;

  // Edges are taken against the value sampled on the previous tick, not the previous clk.
  assign hs_rise = pix_stb & hsync & ~hs_prev_q;
  assign vs_rise = pix_stb & vsync & ~vs_prev_q;
  assign de_fall = pix_stb & ~active & de_prev_q;
  assign timeout = pix_stb & ~hs_rise & (to_cnt_q == TW'(H_TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    de_prev_d     = de_prev_q;
    h_seen_d      = h_seen_q;
    ref_valid_d   = ref_valid_q;
    h_cnt_d       = h_cnt_q;
    a_cnt_d       = a_cnt_q;
    v_cnt_d       = v_cnt_q;
    l_cnt_d       = l_cnt_q;
    to_cnt_d      = to_cnt_q;
    ref_d         = ref_q;
    x_d           = x_q;
    y_d           = y_q;
    h_total_d     = h_total_q;
    h_active_d    = h_active_q;
    v_total_d     = v_total_q;
    v_active_d    = v_active_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    lock_err_d    = 1'b0;

    if (pix_stb) begin
      hs_prev_d = hsync;
      vs_prev_d = vsync;
      de_prev_d = active;
      h_cnt_d   = (&h_cnt_q) ? h_cnt_q : XW'(h_cnt_q + 1'b1);
      to_cnt_d  = TW'(to_cnt_q + 1'b1);

      if (hs_rise) begin
        if (h_seen_q) h_total_d = XW'(h_cnt_q + 1'b1);
        h_seen_d = 1'b1;
        h_cnt_d  = '0;
        v_cnt_d  = YW'(v_cnt_q + 1'b1);
        to_cnt_d = '0;
      end

      if (active) begin
        pix_valid_d = 1'b1;
        x_d         = a_cnt_q;
        y_d         = l_cnt_q;
        a_cnt_d     = (&a_cnt_q) ? a_cnt_q : XW'(a_cnt_q + 1'b1);
      end

      if (de_fall) begin
        h_active_d = a_cnt_q;
        a_cnt_d    = '0;
        l_cnt_d    = YW'(l_cnt_q + 1'b1);
      end

      // Same-tick hsync rise / DE fall belong to the frame that is ending.
      if (vs_rise) begin
        v_total_d     = YW'(v_cnt_q + YW'(hs_rise));
        v_active_d    = YW'(l_cnt_q + YW'(de_fall));
        v_cnt_d       = '0;
        l_cnt_d       = '0;
        frame_start_d = 1'b1;
      end
    end

    snap_c = {h_total_d, h_active_d, v_total_d, v_active_d};

    if (vs_rise) begin
      unique case (state_q)
        ST_SEARCH: begin
          state_d     = ST_MEASURE;
          ref_valid_d = 1'b0;
        end
        ST_MEASURE: begin
          if (ref_valid_q && (ref_q == snap_c)) state_d = ST_LOCKED;
          ref_d       = snap_c;
          ref_valid_d = 1'b1;
        end
        ST_LOCKED: begin
          if (ref_q != snap_c) begin
            state_d    = ST_MEASURE;
            ref_d      = snap_c;
            lock_err_d = 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    // Loss of horizontal sync overrides any frame decision on the same tick.
    if (timeout) begin
      state_d     = ST_SEARCH;
      ref_valid_d = 1'b0;
      h_seen_d    = 1'b0;
      to_cnt_d    = '0;
      lock_err_d  = locked_q;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_SEARCH;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      de_prev_q     <= 1'b0;
      h_seen_q      <= 1'b0;
      ref_valid_q   <= 1'b0;
      h_cnt_q       <= '0;
      a_cnt_q       <= '0;
      v_cnt_q       <= '0;
      l_cnt_q       <= '0;
      to_cnt_q      <= '0;
      ref_q         <= '0;
      pix_valid_q   <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      lock_err_q    <= 1'b0;
      h_total_q     <= '0;
      h_active_q    <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      de_prev_q     <= de_prev_d;
      h_seen_q      <= h_seen_d;
      ref_valid_q   <= ref_valid_d;
      h_cnt_q       <= h_cnt_d;
      a_cnt_q       <= a_cnt_d;
      v_cnt_q       <= v_cnt_d;
      l_cnt_q       <= l_cnt_d;
      to_cnt_q      <= to_cnt_d;
      ref_q         <= ref_d;
      pix_valid_q   <= pix_valid_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      lock_err_q    <= lock_err_d;
      h_total_q     <= h_total_d;
      h_active_q    <= h_active_d;
      v_total_q     <= v_total_d;
      v_active_q    <= v_active_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign lock_err    = lock_err_q;
  assign h_total     = h_total_q;
  assign h_active    = h_active_q;
  assign v_total     = v_total_q;
  assign v_active    = v_active_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Bench for vga_timing_decoder: random small raster geometries, expectations derived from the
// generated raster (line length, DE window, line counts) and the lock rules.
module tb_vga_timing_decoder;

  localparam int XW = 11;
  localparam int YW = 10;
  localparam int H_TIMEOUT = 4095;

  logic          clk = 1'b0;
  logic          reset, pix_stb, hsync, vsync, active;
  logic          pix_valid, frame_start, locked, lock_err;
  logic [XW-1:0] x, h_total, h_active;
  logic [YW-1:0] y, v_total, v_active;

  int total, bad;

  // raster geometry and sparse-strobe spacing
  int gH, gDS, gN, gA, gVS, stb_gap, prevN;

  // reference model state
  bit m_prev_hs, m_prev_vs, m_search, m_have_ref, m_locked, xy_ok, xy_known;
  int t_since, rises, exp_x, exp_y;
  int ref_ht, ref_ha, ref_vt, ref_va;

  always #5 clk = ~clk;

  vga_timing_decoder #(.XW(XW), .YW(YW), .H_TIMEOUT(H_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pix_stb(pix_stb), .hsync(hsync), .vsync(vsync),
    .active(active), .pix_valid(pix_valid), .x(x), .y(y), .frame_start(frame_start),
    .locked(locked), .lock_err(lock_err), .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic new_geom();
    gH  = $urandom_range(40, 24);
    gDS = $urandom_range(gH - 8, 4);
    gA  = $urandom_range(12, 6);
    gVS = gA + $urandom_range(2, 0);
    gN  = gVS + $urandom_range(8, 4);
  endtask

  task automatic model_reset(input bit fresh);
    m_prev_hs  = 1'b0;
    m_prev_vs  = 1'b0;
    t_since    = 0;
    m_search   = 1'b1;
    m_have_ref = 1'b0;
    m_locked   = 1'b0;
    rises      = 0;
    xy_ok      = fresh;
    xy_known   = 1'b1;
    exp_x      = 0;
    exp_y      = 0;
  endtask

  task automatic do_reset(input bit fresh);
    reset = 1'b1; pix_stb = 1'b1; hsync = 1'b1; vsync = 1'b1; active = 1'b1;
    @(posedge clk); #1;
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lock_err", lock_err, 0);
    chk("rst_h_total", h_total, 0);
    chk("rst_h_active", h_active, 0);
    chk("rst_v_total", v_total, 0);
    chk("rst_v_active", v_active, 0);
    reset = 1'b0; pix_stb = 1'b0; hsync = 1'b0; vsync = 1'b0; active = 1'b0;
    model_reset(fresh);
  endtask

  // One pixel tick followed by stb_gap idle clocks; expectations come from the raster position.
  task automatic tick(input bit hs, input bit vs, input bit de, input int px, input int py);
    bit hr, vr, e_err, same;
    hsync = hs; vsync = vs; active = de; pix_stb = 1'b1;
    hr = hs && !m_prev_hs;
    vr = vs && !m_prev_vs;
    m_prev_hs = hs;
    m_prev_vs = vs;
    e_err = 1'b0;
    if (vr) begin
      rises++;
      if (m_search) begin
        m_search   = 1'b0;
        m_have_ref = 1'b0;
      end else begin
        same = m_have_ref && ref_ht == gH && ref_ha == gH - gDS && ref_vt == prevN && ref_va == gA;
        if (m_locked && !same) begin
          m_locked = 1'b0;
          e_err    = 1'b1;
        end else if (!m_locked && same) begin
          m_locked = 1'b1;
        end
        ref_ht = gH; ref_ha = gH - gDS; ref_vt = prevN; ref_va = gA;
        m_have_ref = 1'b1;
      end
      xy_ok = 1'b1;
    end
    if (hr) begin
      t_since = 0;
    end else begin
      t_since++;
      if (t_since == H_TIMEOUT) begin
        e_err    = m_locked;
        m_locked = 1'b0;
        m_search = 1'b1;
        t_since  = 0;
        rises    = 0;
      end
    end

    @(posedge clk); #1;
    chk("pix_valid", pix_valid, de);
    if (de) begin
      if (xy_ok) begin
        chk("x", x, px);
        chk("y", y, py);
        exp_x = px;
        exp_y = py;
      end else begin
        xy_known = 1'b0;
      end
    end
    chk("frame_start", frame_start, vr);
    chk("lock_err", lock_err, e_err);
    chk("locked", locked, m_locked);
    if (vr && rises >= 2) begin
      chk("h_total", h_total, gH);
      chk("h_active", h_active, gH - gDS);
      chk("v_total", v_total, prevN);
      chk("v_active", v_active, gA);
    end
    pix_stb = 1'b0;
    repeat (stb_gap) begin
      @(posedge clk); #1;
      chk("idle_pix_valid", pix_valid, 0);
      chk("idle_frame_start", frame_start, 0);
      chk("idle_lock_err", lock_err, 0);
      chk("idle_locked", locked, m_locked);
      if (xy_known) begin
        chk("idle_x", x, exp_x);
        chk("idle_y", y, exp_y);
      end
    end
  endtask

  // One generated frame of n_lines lines; optional reset just before tick (rl, rp).
  task automatic run_frame(input int n_lines, input int rl, input int rp);
    for (int l = 0; l < n_lines; l++) begin
      for (int p = 0; p < gH; p++) begin
        if (l == rl && p == rp) do_reset(1'b0);
        tick(p < 4, (l >= gVS) && (l < gVS + 3), (l < gA) && (p >= gDS), p - gDS, l);
      end
    end
    prevN = n_lines;
  endtask

  initial begin
    total = 0; bad = 0; stb_gap = 0; prevN = 0;
    ref_ht = 0; ref_ha = 0; ref_vt = 0; ref_va = 0;
    reset = 1'b0; pix_stb = 1'b0; hsync = 1'b0; vsync = 1'b0; active = 1'b0;

    // Fresh lock on a stable raster
    new_geom();
    do_reset(1'b1);
    repeat (3) run_frame(gN, -1, -1);
    chk("lock_after_3_rises", locked, 1);
    run_frame(gN, -1, -1);

    // One long frame breaks lock; two matching frames restore it
    run_frame(gN + 1, -1, -1);
    run_frame(gN, -1, -1);
    chk("unlock_after_long_frame", locked, 0);
    run_frame(gN, -1, -1);
    chk("still_measuring", locked, 0);
    run_frame(gN, -1, -1);
    chk("relock", locked, 1);

    // Loss of hsync drops to search; relock needs three vsync rises
    repeat (4200) tick(1'b0, 1'b0, 1'b0, 0, 0);
    chk("timeout_unlock", locked, 0);
    run_frame(gN, -1, -1);
    run_frame(gN, -1, -1);
    chk("search_relock_pending", locked, 0);
    run_frame(gN, -1, -1);
    chk("search_relock", locked, 1);

    // Sparse strobe: one tick every third clk
    new_geom();
    stb_gap = 2;
    do_reset(1'b1);
    repeat (3) run_frame(gN, -1, -1);
    chk("sparse_lock", locked, 1);
    run_frame(gN, -1, -1);

    // Reset in the middle of an active line
    stb_gap = 0;
    run_frame(gN, gA / 2, gDS + 2);
    chk("midreset_rise1", locked, 0);
    run_frame(gN, -1, -1);
    chk("midreset_rise2", locked, 0);
    run_frame(gN, -1, -1);
    chk("midreset_rise3", locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
